// File: rtl/bf16_pkg.sv
// Shared BF16 constants, field slices and classification type for the BF16 blocks.
package bf16_pkg;

  localparam int BF16_BIAS = 127;
  localparam logic [14:0] BF16_ZERO_MAG = 15'h0000;
  localparam logic [14:0] BF16_INF_MAG  = 15'h7F80;

  localparam int BF16_SIGN_BIT = 15;
  localparam int BF16_EXP_MSB  = 14;
  localparam int BF16_EXP_LSB  = 7;
  localparam int BF16_FRAC_MSB = 6;
  localparam int BF16_FRAC_LSB = 0;
  localparam int BF16_MANT_W   = 8;

  typedef enum logic [1:0] {
    ZERO,
    DENORM,
    NORM,
    NAN
  } bf16_class_t;

endpackage

// File: rtl/bf16_unpack.sv
// Combinational BF16 unpack: classifies the value and inserts the hidden mantissa bit.
module bf16_unpack
  import bf16_pkg::*;
(
  input  logic [15:0]            data,
  output logic                   sign,
  output logic [BF16_MANT_W-1:0] mant,
  output logic [7:0]             exp_eff,
  output bf16_class_t            cls
);

  logic [7:0] exp_field;

  always_comb begin
    exp_field = data[BF16_EXP_MSB:BF16_EXP_LSB];
    sign      = data[BF16_SIGN_BIT];
    mant      = {exp_field != 8'd0, data[BF16_FRAC_MSB:BF16_FRAC_LSB]};
    // Denormals share the scale of the smallest normal exponent.
    exp_eff   = (exp_field == 8'd0) ? 8'd1 : exp_field;
    if (data[14:0] == BF16_ZERO_MAG)
      cls = ZERO;
    else if (data[14:0] >= BF16_INF_MAG)
      cls = NAN;
    else if (exp_field == 8'd0)
      cls = DENORM;
    else
      cls = NORM;
  end

endmodule

// File: rtl/bf16_to_fixed.sv
// Two-stage BF16 -> signed fixed-point decoder with valid/ready on both sides.
// Optional macro BF2FX_ROUND_NEAREST_EN: round-to-nearest-even on right shifts instead of truncation.
module bf16_to_fixed
  import bf16_pkg::*;
#(
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 8,
  parameter int BIAS      = BF16_BIAS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_flags
);

  localparam int MAG_W = OUT_W + 8;
`ifdef BF2FX_ROUND_NEAREST_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam logic [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [MAG_W-1:0] POS_LIM = (MAG_W'(1) << (OUT_W-1)) - MAG_W'(1);
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1) << (OUT_W-1);

  logic                   u_sign;
  logic [BF16_MANT_W-1:0] u_mant;
  logic [7:0]             u_exp;
  bf16_class_t            u_cls;
  logic signed [9:0]      shift_d;

  logic                   ready_en;
  logic                   s1_valid;
  logic                   s1_sign;
  logic [BF16_MANT_W-1:0] s1_m;
  logic signed [9:0]      s1_shift;
  bf16_class_t            s1_cls;
  logic                   s1_advance;
  logic                   s2_valid;

  logic [MAG_W-1:0]       mag;
  logic [MAG_W-1:0]       limit;
  logic [9:0]             rsh;
  logic [15:0]            ext;
  logic                   round_up;
  logic                   ovf;
  logic [OUT_W-1:0]       res_data;
  logic [1:0]             res_flags;

  bf16_unpack u_unpack (
    .data    (in_data),
    .sign    (u_sign),
    .mant    (u_mant),
    .exp_eff (u_exp),
    .cls     (u_cls)
  );

  assign shift_d    = 10'(int'(u_exp) - BIAS + FRAC_BITS - 7);
  assign s1_advance = !s2_valid || out_ready;
  // ready_en holds in_ready low until the first clock after reset release.
  assign in_ready   = ready_en && (!s1_valid || s1_advance);
  assign out_valid  = s2_valid;

  always_comb begin
    mag      = '0;
    ovf      = 1'b0;
    rsh      = 10'(-s1_shift);
    ext      = '0;
    round_up = 1'b0;
    limit    = s1_sign ? NEG_LIM : POS_LIM;
    if (!s1_shift[9]) begin
      if (s1_shift >= $signed(10'(OUT_W)))
        ovf = 1'b1;
      else
        mag = MAG_W'(s1_m) << s1_shift;
    end else begin
      // ext keeps the kept bits in [15:8], guard in [7] and sticky in [6:0].
      if (rsh < 10'd9)
        ext = {s1_m, 8'h00} >> rsh[3:0];
      round_up = ROUND_EN && ext[7] && ((|ext[6:0]) || ext[8]);
      mag      = MAG_W'(ext[15:8]) + MAG_W'(round_up);
    end
    if (mag > limit)
      ovf = 1'b1;

    res_data  = '0;
    res_flags = 2'b00;
    if (s1_cls == NAN) begin
      res_data  = s1_sign ? MIN_VAL : MAX_VAL;
      res_flags = 2'b10;
    end else if (s1_cls == ZERO) begin
      res_data  = '0;
    end else if (ovf) begin
      res_data  = s1_sign ? MIN_VAL : MAX_VAL;
      res_flags = 2'b01;
    end else if (mag != '0) begin
      res_data  = s1_sign ? -mag[OUT_W-1:0] : mag[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_m      <= '0;
      s1_shift  <= '0;
      s1_cls    <= ZERO;
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_flags <= 2'b00;
    end else begin
      ready_en <= 1'b1;
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign  <= u_sign;
          s1_m     <= u_mant;
          s1_shift <= shift_d;
          s1_cls   <= u_cls;
        end
      end
      if (s1_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data  <= res_data;
          out_flags <= res_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_bf16_to_fixed.sv
// Self-checking bench for bf16_to_fixed: directed vector table plus stall and reset sequences.
module tb_bf16_to_fixed;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic [1:0]  flags;
    string       name;
  } vec_t;

`ifdef BF2FX_ROUND_NEAREST_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_flags;

  int checks = 0;
  int errors = 0;

  bf16_to_fixed #(.OUT_W(16), .FRAC_BITS(8), .BIAS(127)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [15:0] data);
    in_valid = valid;
    in_data  = data;
  endtask

  vec_t        vecs[$];
  vec_t        bp_vecs[$];
  logic [17:0] expq[$];
  logic [17:0] exp_item;
  logic [15:0] held_data;
  logic        stalled;
  bit          saw_block;
  int          idx;
  int          received;
  int          max_held;

  initial begin
    vecs.push_back('{16'h3F80, 16'h0100, 2'b00, "one"});
    vecs.push_back('{16'hC020, 16'hFD80, 2'b00, "neg_2p5"});
    vecs.push_back('{16'h3F40, 16'h00C0, 2'b00, "p75"});
    vecs.push_back('{16'h8000, 16'h0000, 2'b00, "neg_zero"});
    vecs.push_back('{16'h4348, 16'h7FFF, 2'b01, "sat_pos"});
    vecs.push_back('{16'hC300, 16'h8000, 2'b00, "min_exact"});
    vecs.push_back('{16'hC301, 16'h8000, 2'b01, "sat_neg"});
    vecs.push_back('{16'h7F80, 16'h7FFF, 2'b10, "inf_pos"});
    vecs.push_back('{16'hFFC1, 16'h8000, 2'b10, "nan_neg"});
    vecs.push_back('{16'h0001, 16'h0000, 2'b00, "denorm"});
    vecs.push_back('{16'h8001, 16'h0000, 2'b00, "neg_denorm"});
    vecs.push_back('{16'h3B40, RND ? 16'h0001 : 16'h0000, 2'b00, "lsb_0p75"});
    vecs.push_back('{16'h3B00, 16'h0000, 2'b00, "lsb_0p5_tie"});
    vecs.push_back('{16'h3C30, RND ? 16'h0003 : 16'h0002, 2'b00, "pos_2p75"});
    vecs.push_back('{16'hBC30, RND ? 16'hFFFD : 16'hFFFE, 2'b00, "neg_2p75"});
    vecs.push_back('{16'h4780, 16'h7FFF, 2'b01, "huge_shift"});
    vecs.push_back('{16'hC380, 16'h8000, 2'b01, "neg_256"});
    vecs.push_back('{16'h3F81, 16'h0102, 2'b00, "one_plus"});

    bp_vecs.push_back('{16'h3F80, 16'h0100, 2'b00, "bp0"});
    bp_vecs.push_back('{16'h4000, 16'h0200, 2'b00, "bp1"});
    bp_vecs.push_back('{16'hC020, 16'hFD80, 2'b00, "bp2"});
    bp_vecs.push_back('{16'h3F40, 16'h00C0, 2'b00, "bp3"});
    bp_vecs.push_back('{16'hBF80, 16'hFF00, 2'b00, "bp4"});
    bp_vecs.push_back('{16'h4348, 16'h7FFF, 2'b01, "bp5"});
    bp_vecs.push_back('{16'h7F80, 16'h7FFF, 2'b10, "bp6"});
    bp_vecs.push_back('{16'h4040, 16'h0300, 2'b00, "bp7"});

    // Reset state
    rst_n     = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 16'h0000);
    #12;
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data", 32'(out_data), 32'h0);
    check_output("rst_out_flags", 32'(out_flags), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_output("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Back-to-back vectors with a fixed 2-cycle latency
    for (int i = 0; i < vecs.size() + 2; i++) begin
      if (i >= 2) begin
        check_output({vecs[i-2].name, "_valid"}, 32'(out_valid), 32'd1);
        check_output({vecs[i-2].name, "_data"}, 32'(out_data), 32'(vecs[i-2].dout));
        check_output({vecs[i-2].name, "_flags"}, 32'(out_flags), 32'(vecs[i-2].flags));
      end
      if (i < vecs.size()) begin
        check_output("stream_in_ready", 32'(in_ready), 32'd1);
        apply_stimulus(1'b1, vecs[i].din);
      end else begin
        apply_stimulus(1'b0, 16'h0000);
      end
      @(negedge clk);
    end
    check_output("drain_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: out_ready low for cycles 3-7
    idx = 0; received = 0; max_held = 0; stalled = 1'b0; saw_block = 1'b0;
    for (int c = 0; c < 60 && received < 8; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      apply_stimulus(idx < 8, (idx < 8) ? bp_vecs[idx].din : 16'h0000);
      #1;
      if (stalled) begin
        check_output("stall_valid_held", 32'(out_valid), 32'd1);
        check_output("stall_data_held", 32'(out_data), 32'(held_data));
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          errors++;
          checks++;
          $display("[TB] FAIL bp_extra_output: got 0x%0h, expected no output", out_data);
        end else begin
          exp_item = expq.pop_front();
          check_output("bp_data", 32'(out_data), 32'(exp_item[17:2]));
          check_output("bp_flags", 32'(out_flags), 32'(exp_item[1:0]));
        end
        received++;
      end
      if (in_valid && in_ready) begin
        expq.push_back({bp_vecs[idx].dout, bp_vecs[idx].flags});
        idx++;
      end
      if (expq.size() > max_held) max_held = expq.size();
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      @(negedge clk);
    end
    check_output("bp_received", 32'(received), 32'd8);
    check_output("bp_max_held", 32'(max_held), 32'd2);
    check_output("bp_in_ready_dropped", 32'(saw_block), 32'd1);
    check_output("bp_queue_empty", 32'(expq.size()), 32'd0);

    // Reset with two items in flight
    out_ready = 1'b0;
    apply_stimulus(1'b1, 16'h3F80);
    @(negedge clk) apply_stimulus(1'b1, 16'h4000);
    @(negedge clk) apply_stimulus(1'b0, 16'h0000);
    check_output("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(out_valid), 32'd0);
    check_output("mid_rst_data", 32'(out_data), 32'h0);
    out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    check_output("post_rst_in_ready", 32'(in_ready), 32'd1);
    apply_stimulus(1'b1, 16'hC020);
    @(negedge clk) apply_stimulus(1'b0, 16'h0000);
    check_output("post_rst_lat1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_output("post_rst_lat2_valid", 32'(out_valid), 32'd1);
    check_output("post_rst_lat2_data", 32'(out_data), 32'hFD80);
    @(negedge clk);
    check_output("post_rst_single", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf16_to_fixed.md
Name: bf16_to_fixed

Overview:
- Streaming decoder from BF16 to signed two's-complement fixed point, which is the inverse direction of the BF16 adder datapath.
- Converts BF16 activations and partial sums into integer-domain values for the quantised VGG16 post-processing path (pooling, requantisation, output writeback).
- Two-stage pipeline with valid/ready handshakes on both sides; sustains one result per cycle.

Parameters:
- OUT_W, 16, output width in bits, signed.
- FRAC_BITS, 8, fractional bits of the output format (Q(OUT_W-FRAC_BITS).FRAC_BITS).
- BIAS, 127, BF16 exponent bias.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  16  BF16 input {sign, exp[7:0], frac[6:0]}.
- out_valid  out  1  out_data/out_flags valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  OUT_W  signed fixed-point result.
- out_flags  out  2  {nan, sat}.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n).
- Reset: all stage valid bits clear; out_valid=0, out_data=0, out_flags=0. in_ready=1 one cycle after rst_n deasserts.
- Reset mid-operation: in-flight items are discarded and nothing is emitted.
- Handshake:
  - Transfer occurs when valid && ready.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready.
  - out_valid/out_data/out_flags stay stable while out_valid && !out_ready.
  - Latency is 2 cycles from input accept to out_valid with no stall. Throughput is 1/cycle.
  - Under backpressure, at most 2 items are held. There is no loss or reordering.
- Stage 1 (unpack/classify), registered:
  - Classes: zero, when in_data[14:0]==0 (covers -0); nan, when in_data[14:0] >= 15'h7F80 (Inf and NaN); denormal, when exp==0.
  - Mantissa m[7:0] = {exp!=0, frac}.
  - Effective exponent e = denormal ? 1 : exp.
  - Registers: sign, m, signed shift = e - BIAS + FRAC_BITS - 7 (10-bit signed), class bits.
- Stage 2 (align/sign/saturate), registered:
  - shift >= 0: mag = m << shift. If shift >= OUT_W, or mag exceeds the limit, set overflow.
  - shift < 0: mag = m >> -shift, truncating toward zero. If -shift >= 8, mag = 0.
  - Positive limit: 2^(OUT_W-1)-1. Negative limit: 2^(OUT_W-1), so the most negative value is exact.
  - Overflow: result = sign ? min (0x8000) : max (0x7FFF), with sat=1.
  - nan class: saturated by sign, nan=1, sat=0.
  - zero class, or any result with mag==0: out_data=0 (never negative zero), flags=0.
  - Otherwise: out_data = sign ? -mag : mag.
- Intermediate widths: mag computed in OUT_W+8 bits before comparison, so no wrap-around occurs.

Optional Feature:
- Macro BF2FX_ROUND_NEAREST_EN.
- Defined: right shifts round to nearest, ties-to-even, using guard and sticky bits from the discarded mantissa. A round-up that carries past the limit sets sat and saturates. Latency is unchanged.
- Undefined: truncation toward zero, matching the adder's truncating alignment.

Decomposition:
- Shared package bf16_pkg holds:
  - BF16_BIAS=127, BF16_ZERO_MAG=15'h0000, BF16_INF_MAG=15'h7F80.
  - Field-slice constants for sign/exp/frac.
  - A bf16_class_t enum {ZERO, DENORM, NORM, NAN}.
- One natural sub-module, bf16_unpack: combinational classify and hidden-bit insertion. Future BF16 blocks can reuse it.
- Handshake/pipeline control stays in the top module.

Test Plan (OUT_W=16, FRAC_BITS=8):
- Basic values, back-to-back with out_ready=1:
  - 0x3F80 -> 0x0100.
  - 0xC020 -> 0xFD80 (-2.5).
  - 0x3F40 -> 0x00C0.
  - 0x8000 -> 0x0000, flags=0.
  - Each result appears 2 cycles after its input, one per cycle.
- Saturation:
  - 0x4348 (200.0) -> 0x7FFF, sat=1.
  - 0xC300 (-128.0) -> 0x8000, sat=0.
  - 0xC301 -> 0x8000, sat=1.
- Specials:
  - 0x7F80 -> 0x7FFF, nan=1.
  - 0xFFC1 -> 0x8000, nan=1.
  - Denormal 0x0001 -> 0x0000.
  - 0x3B40 (0.75 LSB) -> 0x0000 truncate; 0x0001 with BF2FX_ROUND_NEAREST_EN.
  - 0x3B00 (0.5 LSB) -> 0x0000 in both modes (tie to even).
- Backpressure:
  - Stream 8 values with out_ready=0 for cycles 3-7: in_ready drops once 2 items are held.
  - out_data stays stable while stalled.
  - All 8 outputs arrive in order, with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 items in flight -> out_valid=0 immediately; no stale output after release; the first new input emerges 2 cycles after its accept.
